vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised multi-mode VGA timing generator, the successor to the single-mode fixed sync generator. It holds a built-in table of four standard modes, selectable at run time, and switches mode only at a frame boundary so every frame is intact. A pixel-clock prescaler lets a fast system clock drive slower modes. It also adds line/frame strobes and mode status for downstream glyph, pixel and fetch logic.

Parameters:
CLK_DIV, 1, system clocks per pixel tick (1..16); 1 = advance every cycle
DEFAULT_MODE, 3, mode index loaded on reset (0..3)
HW, 11, hpos width; must hold max H total - 1 (1343)
VW, 10, vpos width; must hold max V total - 1 (805)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode_sel  in  2  requested mode; sampled only at frame boundary
pix_en  out  1  pixel tick strobe; counters advance only when high
hpos  out  HW  horizontal pixel counter
vpos  out  VW  vertical line counter
hsync  out  1  horizontal sync, polarity per active mode
vsync  out  1  vertical sync, polarity per active mode
display_on  out  1  high inside the active area
line_start  out  1  one-clk pulse, first cycle of each new line
frame_start  out  1  one-clk pulse, first cycle of each new frame
active_mode  out  2  mode currently being generated
mode_pending  out  1  mode_sel != active_mode (change queued)

Behaviour:
- Clock/reset: one clock (clk). reset is asynchronous and active-high; all state clears immediately on assertion and stays cleared while it is held.
- Mode table. Each entry gives H active/front/sync/back, H polarity, V active/front/sync/back, V polarity (1 = positive sync):
  0: 640/16/96/48 neg, 480/10/2/33 neg (800x525)
  1: 768/24/80/104 neg, 576/1/3/17 pos (976x597)
  2: 800/40/128/88 pos, 600/1/4/23 pos (1056x628)
  3: 1024/24/136/160 neg, 768/3/6/29 neg (1344x806)
- Reset values:
  - hpos=0, vpos=0, active_mode=DEFAULT_MODE, divider=0.
  - line_start=0, frame_start=0, mode_pending=0.
  - hsync and vsync at the inactive level of DEFAULT_MODE.
  - display_on is registered 0 and becomes 1 on the first clk after release.
- Prescaler: 4-bit divider counts 0..CLK_DIV-1 and wraps. pix_en = (divider == CLK_DIV-1), decoded combinationally. With CLK_DIV=1, pix_en is constantly 1.
- Counters, on a pix_en cycle:
  - If hpos == Htot-1: hpos <= 0.
    - If vpos == Vtot-1: vpos <= 0.
    - Otherwise: vpos <= vpos+1.
  - Otherwise: hpos <= hpos+1.
- Mode switch:
  - Taken only on the pix_en cycle where hpos == Htot-1 and vpos == Vtot-1 (last pixel of the frame).
  - On that cycle, active_mode <= mode_sel. The next frame starts at (0,0) with the new timing.
  - mode_sel changes at any other time have no effect on the current frame.
  - Multiple changes within one frame: only the value present at the boundary is taken.
- Outputs hsync, vsync, display_on are registered and computed from the next counter values and next mode. They therefore always match the hpos/vpos/active_mode values presented in the same cycle (zero skew).
  - hsync active when H_act+H_fp <= hpos < H_act+H_fp+H_sync.
  - vsync active when V_act+V_fp <= vpos < V_act+V_fp+V_sync.
  - Output level = active XNOR polarity bit, i.e. polarity=0 drives 0 while active.
  - display_on = (hpos < H_act) && (vpos < V_act).
- line_start: registered; high for exactly one clk, in the cycle where hpos first becomes 0. With CLK_DIV>1 it does not repeat while hpos holds 0.
- frame_start: same rule, for (hpos, vpos) first becoming (0,0). It coincides with line_start.
- Reset release: no strobes are issued for the reset-state (0,0). The first frame_start is at the first wrap.
- mode_pending: registered (mode_sel != active_mode). It clears on the cycle after the switch.
- Reset mid-frame: counters return to (0,0) and mode returns to DEFAULT_MODE. Any pending change is discarded.

Test Plan:
- Reset, CLK_DIV=1, mode_sel=3 held -> hpos reaches 1343 then 0. frame_start period = 1344*806 = 1083264 clks. hsync low for 136 clks starting at hpos=1048. vsync low for 6 lines starting at vpos=771.
- mode_sel=2 applied mid-frame -> mode_pending=1 the next clk; active_mode stays 3 until the frame's last pixel. The next frame shows H total 1056, positive hsync at hpos 840..967, and mode_pending=0.
- Mode 0 with CLK_DIV=4 -> pix_en every 4th clk. Line period 3200 clks; each line_start is one clk wide. display_on is high for 640 ticks per line on lines 0..479.
- Toggle mode_sel 0->1->0 within one frame, ending at 0 before the boundary -> no switch occurs; mode_pending returns to 0.
- Assert reset asynchronously mid-line (between clk edges) -> outputs clear before the next edge: hpos=vpos=0, active_mode=3, hsync/vsync=1. No frame_start until the first wrap.
- Mode 1 frame -> vsync high (positive) on vpos 577..579; hsync low on hpos 792..871; zero skew versus hpos/vpos checked every cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Multi-mode VGA timing generator. A built-in table holds four standard modes;
// the requested mode is adopted only on the last pixel of a frame, so every
// frame is generated with one consistent timing. A prescaler turns the system
// clock into a pixel tick, and the raster counters advance only on that tick.
//
// All sync/display outputs are registered from the *next* counter and mode
// values, so they line up with hpos/vpos/active_mode in the same cycle.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   mode_sel      requested mode, taken only at a frame boundary
//   pix_en        pixel tick strobe (combinational decode of the prescaler)
//   hpos, vpos    horizontal pixel / vertical line counters
//   hsync, vsync  sync outputs, polarity taken from the active mode
//   display_on    high inside the active picture area
//   line_start    one-clk pulse on the first cycle of each new line
//   frame_start   one-clk pulse on the first cycle of each new frame
//   active_mode   mode currently being generated
//   mode_pending  mode_sel differs from the mode in effect
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV      = 1,   // system clocks per pixel tick (1..16)
  parameter int DEFAULT_MODE = 3,   // mode loaded on reset (0..3)
  parameter int HW           = 11,  // hpos width
  parameter int VW           = 10   // vpos width
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode_sel,
  output logic          pix_en,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start,
  output logic [1:0]    active_mode,
  output logic          mode_pending
);

  // Per-mode timing, stored as the comparison thresholds the counters need
  // rather than raw porch widths.
  typedef struct packed {
    logic [HW-1:0] h_act;     // first non-visible pixel
    logic [HW-1:0] hs_start;  // first pixel of the sync pulse
    logic [HW-1:0] hs_end;    // first pixel after the sync pulse
    logic [HW-1:0] h_last;    // H total - 1
    logic          h_pol;     // 1 = positive sync
    logic [VW-1:0] v_act;
    logic [VW-1:0] vs_start;
    logic [VW-1:0] vs_end;
    logic [VW-1:0] v_last;    // V total - 1
    logic          v_pol;
  } timing_t;

  function automatic timing_t make_timing(
    input int   ha, input int hf, input int hs, input int hb, input logic hp,
    input int   va, input int vf, input int vs, input int vb, input logic vp
  );
    timing_t t;
    t.h_act    = HW'(ha);
    t.hs_start = HW'(ha + hf);
    t.hs_end   = HW'(ha + hf + hs);
    t.h_last   = HW'(ha + hf + hs + hb - 1);
    t.h_pol    = hp;
    t.v_act    = VW'(va);
    t.vs_start = VW'(va + vf);
    t.vs_end   = VW'(va + vf + vs);
    t.v_last   = VW'(va + vf + vs + vb - 1);
    t.v_pol    = vp;
    return t;
  endfunction

  //                          H act/fp/sync/back  pol    V act/fp/sync/back pol
  localparam timing_t MODE_TAB [4] = '{
    make_timing( 640, 16,  96,  48, 1'b0,  480, 10, 2, 33, 1'b0),  //  800 x 525
    make_timing( 768, 24,  80, 104, 1'b0,  576,  1, 3, 17, 1'b1),  //  976 x 597
    make_timing( 800, 40, 128,  88, 1'b1,  600,  1, 4, 23, 1'b1),  // 1056 x 628
    make_timing(1024, 24, 136, 160, 1'b0,  768,  3, 6, 29, 1'b0)   // 1344 x 806
  };

  localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]    div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_q;

  // ---------------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic [1:0]    mode_nxt;
  logic          h_at_last;
  logic          v_at_last;
  logic          line_wrap;
  logic          frame_wrap;
  logic          hs_act;
  logic          vs_act;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          display_nxt;

  // With CLK_DIV = 1 DIV_LAST is 0, so the divider never leaves 0 and the
  // tick is permanently high.
  assign pix_en = (div_cnt == DIV_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // that is what keeps this block free of inferred latches.
    h_nxt    = h_cnt;
    v_nxt    = v_cnt;
    mode_nxt = mode_q;

    h_at_last  = (h_cnt == MODE_TAB[mode_q].h_last);
    v_at_last  = (v_cnt == MODE_TAB[mode_q].v_last);
    line_wrap  = pix_en && h_at_last;
    frame_wrap = line_wrap && v_at_last;

    if (pix_en) begin
      if (h_at_last) begin
        h_nxt = '0;
        if (v_at_last) begin
          v_nxt    = '0;
          // Last pixel of the frame: the only point a new mode is adopted.
          mode_nxt = mode_sel;
        end else begin
          v_nxt = v_cnt + VW'(1);
        end
      end else begin
        h_nxt = h_cnt + HW'(1);
      end
    end

    // Decode against the values the counters are about to hold, so the
    // registered outputs carry no skew relative to hpos/vpos.
    hs_act = (h_nxt >= MODE_TAB[mode_nxt].hs_start) &&
             (h_nxt <  MODE_TAB[mode_nxt].hs_end);
    vs_act = (v_nxt >= MODE_TAB[mode_nxt].vs_start) &&
             (v_nxt <  MODE_TAB[mode_nxt].vs_end);

    // Active XNOR polarity: a negative-sync mode drives 0 while active.
    hsync_nxt   = ~(hs_act ^ MODE_TAB[mode_nxt].h_pol);
    vsync_nxt   = ~(vs_act ^ MODE_TAB[mode_nxt].v_pol);
    display_nxt = (h_nxt < MODE_TAB[mode_nxt].h_act) &&
                  (v_nxt < MODE_TAB[mode_nxt].v_act);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: everything here is plain control state, so all of it is reset;
      // the syncs start at the inactive level of the default mode.
      div_cnt      <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      mode_q       <= DEF_MODE;
      hsync        <= ~MODE_TAB[DEF_MODE].h_pol;
      vsync        <= ~MODE_TAB[DEF_MODE].v_pol;
      display_on   <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      mode_pending <= 1'b0;
    end else begin
      div_cnt      <= pix_en ? 4'd0 : div_cnt + 4'd1;
      h_cnt        <= h_nxt;
      v_cnt        <= v_nxt;
      mode_q       <= mode_nxt;
      hsync        <= hsync_nxt;
      vsync        <= vsync_nxt;
      display_on   <= display_nxt;
      // Strobes fire only on an actual wrap, so a held hpos = 0 (slow tick)
      // or the reset-state origin never produces a repeat.
      line_start   <= line_wrap;
      frame_start  <= frame_wrap;
      // Compared with the mode about to be in effect, so the flag drops in
      // the same cycle the new mode appears on active_mode.
      mode_pending <= (mode_sel != mode_nxt);
    end
  end

  assign hpos        = h_cnt;
  assign vpos        = v_cnt;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Two instances share clk/reset:
//   dut  : CLK_DIV = 1, DEFAULT_MODE = 3 (mode switching, sync placement)
//   dut4 : CLK_DIV = 4, DEFAULT_MODE = 0 (prescaler and strobe width)
// Full frames are far too long to simulate, so the bench deposits the raster
// counters of dut near the region of interest and continues from there.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode_sel;
  logic [1:0]  mode_sel4;

  logic        pix_en, hsync, vsync, display_on, line_start, frame_start, mode_pending;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic [1:0]  active_mode;

  logic        pix_en4, hsync4, vsync4, display_on4, line_start4, frame_start4, mode_pending4;
  logic [10:0] hpos4;
  logic [9:0]  vpos4;
  logic [1:0]  active_mode4;

  vga_timing_gen #(.CLK_DIV(1), .DEFAULT_MODE(3), .HW(11), .VW(10)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel),
    .pix_en(pix_en), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start), .frame_start(frame_start),
    .active_mode(active_mode), .mode_pending(mode_pending)
  );

  vga_timing_gen #(.CLK_DIV(4), .DEFAULT_MODE(0), .HW(11), .VW(10)) dut4 (
    .clk(clk), .reset(reset), .mode_sel(mode_sel4),
    .pix_en(pix_en4), .hpos(hpos4), .vpos(vpos4), .hsync(hsync4), .vsync(vsync4),
    .display_on(display_on4), .line_start(line_start4), .frame_start(frame_start4),
    .active_mode(active_mode4), .mode_pending(mode_pending4)
  );

  always #5 clk = ~clk;

  // Hand-derived mode table (sync ranges are [LO, HI)).
  localparam int H_TOT [4] = '{800, 976, 1056, 1344};
  localparam int H_ACT [4] = '{640, 768, 800, 1024};
  localparam int HS_LO [4] = '{656, 792, 840, 1048};
  localparam int HS_HI [4] = '{752, 872, 968, 1184};
  localparam int HPOL  [4] = '{0, 0, 1, 0};
  localparam int V_TOT [4] = '{525, 597, 628, 806};
  localparam int V_ACT [4] = '{480, 576, 600, 768};
  localparam int VS_LO [4] = '{490, 577, 601, 771};
  localparam int VS_HI [4] = '{492, 580, 605, 777};
  localparam int VPOL  [4] = '{0, 1, 1, 0};

  int n_vec = 0;
  int n_err = 0;

  // Reference raster state for dut.
  int eh, ev, em, els, efs;

  // Deposit values for the counter jump.
  logic [10:0] jh;
  logic [9:0]  jv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of dut: advance the reference raster on the edge, then compare
  // every output at the following falling edge.
  task automatic tick(input bit chk);
    int hs_e, vs_e, de;
    @(posedge clk);
    els = 0;
    efs = 0;
    if (eh == H_TOT[em] - 1) begin
      eh  = 0;
      els = 1;
      if (ev == V_TOT[em] - 1) begin
        ev  = 0;
        efs = 1;
        em  = int'(mode_sel);
      end else begin
        ev++;
      end
    end else begin
      eh++;
    end
    @(negedge clk);
    if (chk) begin
      hs_e = (eh >= HS_LO[em] && eh < HS_HI[em]) ? HPOL[em] : 1 - HPOL[em];
      vs_e = (ev >= VS_LO[em] && ev < VS_HI[em]) ? VPOL[em] : 1 - VPOL[em];
      de   = (eh < H_ACT[em] && ev < V_ACT[em]) ? 1 : 0;
      check("hpos",         32'(hpos),         32'(eh));
      check("vpos",         32'(vpos),         32'(ev));
      check("active_mode",  32'(active_mode),  32'(em));
      check("hsync",        32'(hsync),        32'(hs_e));
      check("vsync",        32'(vsync),        32'(vs_e));
      check("display_on",   32'(display_on),   32'(de));
      check("line_start",   32'(line_start),   32'(els));
      check("frame_start",  32'(frame_start),  32'(efs));
      check("mode_pending", 32'(mode_pending), 32'(int'(mode_sel) != em));
    end
  endtask

  // Place dut's raster at (h, v); called just after a falling edge.
  task automatic jump(input int h, input int v);
    jh = 11'(h);
    jv = 10'(v);
    force dut.h_cnt = jh;
    force dut.v_cnt = jv;
    #1;
    release dut.h_cnt;
    release dut.v_cnt;
    eh = h;
    ev = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last_pix, pix_cnt, gap_bad, ls_cnt, ls1, ls2, ls_wide, prev_ls4;
    int disp4_cnt, hs4_low, hs1_low, cnt, fs_cnt, ls_seen;

    mode_sel  = 2'd3;
    mode_sel4 = 2'd0;
    eh = 0; ev = 0; em = 3; els = 0; efs = 0;
    jh = '0; jv = '0;

    // ---------------- reset state ----------------
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.hpos",         32'(hpos),         32'(0));
    check("rst.vpos",         32'(vpos),         32'(0));
    check("rst.active_mode",  32'(active_mode),  32'(3));
    check("rst.hsync",        32'(hsync),        32'(1));
    check("rst.vsync",        32'(vsync),        32'(1));
    check("rst.display_on",   32'(display_on),   32'(0));
    check("rst.line_start",   32'(line_start),   32'(0));
    check("rst.frame_start",  32'(frame_start),  32'(0));
    check("rst.mode_pending", 32'(mode_pending), 32'(0));
    check("rst.pix_en",       32'(pix_en),       32'(1));
    check("rst4.active_mode", 32'(active_mode4), 32'(0));
    check("rst4.hsync",       32'(hsync4),       32'(1));
    check("rst4.vsync",       32'(vsync4),       32'(1));
    check("rst4.pix_en",      32'(pix_en4),      32'(0));
    check("rst4.hpos",        32'(hpos4),        32'(0));
    check("rst4.vpos",        32'(vpos4),        32'(0));
    check("rst4.display_on",  32'(display_on4),  32'(0));
    check("rst4.strobes",     32'({line_start4, frame_start4, mode_pending4}), 32'(0));

    // ---------------- free run: mode 3 at full rate, mode 0 at /4 ----------------
    reset = 1'b0;
    last_pix = -1; pix_cnt = 0; gap_bad = 0; ls_cnt = 0; ls1 = -1; ls2 = -1;
    ls_wide = 0; prev_ls4 = 0; disp4_cnt = 0; hs4_low = 0; hs1_low = 0;
    for (int i = 0; i < 6500; i++) begin
      tick(1'b1);
      if (ev == 1 && !hsync) hs1_low++;
      if (pix_en4) begin
        if (last_pix >= 0 && i - last_pix != 4) gap_bad++;
        last_pix = i;
        pix_cnt++;
      end
      if (line_start4) begin
        ls_cnt++;
        if (prev_ls4 != 0) ls_wide++;
        if (ls_cnt == 1) ls1 = i;
        if (ls_cnt == 2) ls2 = i;
      end
      prev_ls4 = int'(line_start4);
      if (ls_cnt == 1 && display_on4) disp4_cnt++;
      if (ls_cnt == 1 && !hsync4) hs4_low++;
    end
    check("m3.hsync_low_clks",   32'(hs1_low),       32'(136));
    check("div4.pix_en_count",   32'(pix_cnt),       32'(1625));
    check("div4.pix_en_gap",     32'(gap_bad),       32'(0));
    check("div4.line_starts",    32'(ls_cnt),        32'(2));
    check("div4.first_line",     32'(ls1),           32'(3199));
    check("div4.line_period",    32'(ls2 - ls1),     32'(3200));
    check("div4.line_start_wide",32'(ls_wide),       32'(0));
    check("div4.display_clks",   32'(disp4_cnt),     32'(2560));
    check("div4.hsync_low_clks", 32'(hs4_low),       32'(384));
    check("div4.hpos_end",       32'(hpos4),         32'(25));
    check("div4.vpos_end",       32'(vpos4),         32'(2));

    // ---------------- mode 3 vsync edges ----------------
    jump(1340, 770);
    repeat (4) tick(1'b1);
    check("m3.vsync_on_771",  32'(vsync), 32'(0));
    jump(1340, 776);
    repeat (3) tick(1'b1);
    check("m3.vsync_on_776",  32'(vsync), 32'(0));
    tick(1'b1);
    check("m3.vsync_off_777", 32'(vsync), 32'(1));

    // ---------------- mode switch 3 -> 2 at frame boundary ----------------
    mode_sel = 2'd2;
    tick(1'b1);
    check("sw.pending_set",  32'(mode_pending), 32'(1));
    check("sw.mode_held",    32'(active_mode),  32'(3));
    repeat (20) tick(1'b1);
    jump(1338, 805);
    repeat (5) tick(1'b1);
    check("sw.last_pixel_h", 32'(hpos),         32'(1343));
    check("sw.last_pixel_m", 32'(active_mode),  32'(3));
    tick(1'b1);
    check("sw.new_mode",     32'(active_mode),  32'(2));
    check("sw.frame_start",  32'(frame_start),  32'(1));
    check("sw.line_start",   32'(line_start),   32'(1));
    check("sw.origin",       32'({hpos, 1'b0, vpos}), 32'(0));
    check("sw.hsync_idle",   32'(hsync),        32'(0));
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(1'b1);
      if (ev == 0 && hsync) cnt++;
      if (i == 2) check("sw.pending_clear", 32'(mode_pending), 32'(0));
    end
    check("m2.hsync_high_clks", 32'(cnt), 32'(128));

    // ---------------- toggle within a frame: no switch ----------------
    mode_sel = 2'd0;
    tick(1'b1);
    check("tog.pending_0",   32'(mode_pending), 32'(1));
    mode_sel = 2'd1;
    tick(1'b1);
    check("tog.pending_1",   32'(mode_pending), 32'(1));
    mode_sel = 2'd2;
    tick(1'b1);
    check("tog.pending_off", 32'(mode_pending), 32'(0));
    jump(1050, 627);
    repeat (6) tick(1'b1);
    check("tog.mode_kept",   32'(active_mode),  32'(2));
    check("tog.frame_start", 32'(frame_start),  32'(1));

    // ---------------- mode 1 frame ----------------
    mode_sel = 2'd1;
    jump(1050, 627);
    repeat (6) tick(1'b1);
    check("m1.mode",       32'(active_mode), 32'(1));
    check("m1.vsync_idle", 32'(vsync),       32'(0));
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b1);
      if (ev == 0 && !hsync) cnt++;
    end
    check("m1.hsync_low_clks", 32'(cnt), 32'(80));
    jump(970, 576);
    repeat (6) tick(1'b1);
    check("m1.vsync_on_577",  32'(vsync), 32'(1));
    jump(970, 579);
    repeat (5) tick(1'b1);
    check("m1.vsync_on_579",  32'(vsync), 32'(1));
    tick(1'b1);
    check("m1.vsync_off_580", 32'(vsync), 32'(0));

    // ---------------- asynchronous reset mid-line ----------------
    mode_sel = 2'd2;
    repeat (30) tick(1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst.hpos",         32'(hpos),         32'(0));
    check("arst.vpos",         32'(vpos),         32'(0));
    check("arst.active_mode",  32'(active_mode),  32'(3));
    check("arst.hsync",        32'(hsync),        32'(1));
    check("arst.vsync",        32'(vsync),        32'(1));
    check("arst.display_on",   32'(display_on),   32'(0));
    check("arst.mode_pending", 32'(mode_pending), 32'(0));
    @(negedge clk);
    mode_sel = 2'd3;
    reset = 1'b0;
    eh = 0; ev = 0; em = 3;
    fs_cnt = 0; ls_seen = 0;
    for (int i = 0; i < 1500; i++) begin
      tick(1'b1);
      if (frame_start) fs_cnt++;
      if (line_start) ls_seen++;
    end
    check("arst.no_frame_start", 32'(fs_cnt),  32'(0));
    check("arst.one_line_start", 32'(ls_seen), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
